// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-access memory sequencer with RV32I
// size/sign handling, alignment/legality checks and a bounded ready wait.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_off;

  logic          illegal_c;
  logic          unaligned_c;
  logic [3:0]    st_strb_c;
  logic [31:0]   st_data_c;

  // Pick the addressed byte/halfword lane and extend it per funct3.
  function automatic logic [31:0] extract(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    illegal_c   = 1'b0;
    unaligned_c = 1'b0;
    st_strb_c   = 4'b1111;
    st_data_c   = wdata;
    if (we) illegal_c = funct3[2] | (funct3[1:0] == 2'b11);
    else    illegal_c = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b00: begin
        st_strb_c = 4'b0001 << addr[1:0];
        st_data_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        unaligned_c = addr[0];
        st_strb_c   = 4'b0011 << addr[1:0];
        st_data_c   = {2{wdata[15:0]}};
      end
      default: unaligned_c = |addr[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          err      <= 1'b0;
          wait_cnt <= '0;
          if (req) begin
            busy <= 1'b1;
            if (illegal_c) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (unaligned_c) begin
              state    <= RESP;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state     <= ACCESS;
              mem_valid <= 1'b1;
              mem_we    <= we;
              mem_wstrb <= we ? st_strb_c : 4'b0000;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= st_data_c;
              lat_f3    <= funct3;
              lat_off   <= addr[1:0];
            end
          end
        end
        ACCESS: begin
          if (mem_ready || wait_cnt == WAIT_LAST) begin
            state     <= RESP;
            done      <= 1'b1;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (!mem_ready) err <= 1'b1;
            else if (!mem_we) rdata <= extract(lat_f3, lat_off, mem_rdata);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          misalign <= 1'b0;
          err      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_valid <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus queues expected memory requests and
// completions; responder and done monitors pop and compare independently.
module tb_lsu_ctrl;

  localparam int unsigned MW = 15;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, err;
  logic [31:0] rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        ready_r = 1'b0;
  logic        ready_kick = 1'b0;
  assign mem_ready = ready_r | ready_kick;

  lsu_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .err(err), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
  } mem_exp_t;

  typedef struct {
    logic        mis;
    logic        er;
    logic [31:0] rd;
    int          lat;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_edge = 0;
  int rdly = NEVER;
  int vlen = 0;
  int last_vlen = 0;
  int valid_total = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: raises ready after rdly valid cycles and checks the request.
  always @(negedge clk) begin
    if (mem_valid) begin
      vlen++;
      valid_total++;
      if (vlen - 1 == rdly) begin
        ready_r = 1'b1;
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_access", 32'd1, 32'd0);
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          chk("mem_addr", mem_addr, e.a);
          chk("mem_we", 32'(mem_we), 32'(e.w));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.s));
          chk("mem_wdata", mem_wdata, e.d);
        end
      end else begin
        ready_r = 1'b0;
      end
    end else begin
      if (vlen != 0) last_vlen = vlen;
      vlen = 0;
      ready_r = 1'b0;
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      chk("mem_wstrb_idle", 32'(mem_wstrb), 32'd0);
    end
  end

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (resp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        resp_exp_t r;
        r = resp_q.pop_front();
        chk("misalign", 32'(misalign), 32'(r.mis));
        chk("err", 32'(err), 32'(r.er));
        chk("rdata", rdata, r.rd);
        chk("latency", 32'(cyc + 1 - req_edge), 32'(r.lat));
      end
    end else if (rst_n) begin
      chk("flags_without_done", 32'({misalign, err}), 32'd0);
    end
  end

  task automatic drive_req(input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req_edge = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] mrd, input int rd,
                      input logic [3:0] es, input logic [31:0] ewd,
                      input logic emis, input logic eerr,
                      input logic [31:0] erd, input int elat);
    int start;
    mem_exp_t  me;
    resp_exp_t re;
    if (rd < NEVER && !emis && !eerr) begin
      me.a = {a[31:2], 2'b00}; me.w = w; me.s = es; me.d = ewd;
      mem_q.push_back(me);
    end
    re.mis = emis; re.er = eerr; re.rd = erd; re.lat = elat;
    resp_q.push_back(re);
    rdly = rd;
    mem_rdata = mrd;
    start = done_count;
    drive_req(w, f3, a, wd);
    for (int i = 0; i < 60 && done_count == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_count == start) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int vt;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", 32'({misalign, err}), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // LB sign-extend from lane 2
    xact(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 0, 4'b0000, 32'h0,
         1'b0, 1'b0, 32'hFFFFFFF4, 2);
    // SB to lane 3
    xact(1'b1, 3'b000, 32'h203, 32'hAB, 32'h0, 2, 4'b1000, 32'hABABABAB,
         1'b0, 1'b0, 32'hFFFFFFF4, 4);
    // misaligned LW: no memory access
    vt = valid_total;
    xact(1'b0, 3'b010, 32'h006, 32'h0, 32'h55555555, 0, 4'b0000, 32'h0,
         1'b1, 1'b0, 32'hFFFFFFF4, 1);
    chk("misalign_no_mem_valid", 32'(valid_total), 32'(vt));
    // LHU timeout
    xact(1'b0, 3'b101, 32'h000, 32'h0, 32'h77777777, NEVER, 4'b0000, 32'h0,
         1'b0, 1'b1, 32'hFFFFFFF4, MW + 1);
    chk("timeout_valid_cycles", 32'(last_vlen), 32'(MW));
    // illegal store code beats misalignment
    xact(1'b1, 3'b011, 32'h001, 32'h0, 32'h0, 0, 4'b0000, 32'h0,
         1'b0, 1'b1, 32'hFFFFFFF4, 1);
    // LH sign-extend upper half
    xact(1'b0, 3'b001, 32'h002, 32'h0, 32'h80010000, 1, 4'b0000, 32'h0,
         1'b0, 1'b0, 32'hFFFF8001, 3);
    // SH to upper half
    xact(1'b1, 3'b001, 32'h002, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD,
         1'b0, 1'b0, 32'hFFFF8001, 2);
    // SW
    xact(1'b1, 3'b010, 32'h008, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF,
         1'b0, 1'b0, 32'hFFFF8001, 2);
    // LBU lane 1
    xact(1'b0, 3'b100, 32'h001, 32'h0, 32'h00009A00, 3, 4'b0000, 32'h0,
         1'b0, 1'b0, 32'h0000009A, 5);
    // LW
    xact(1'b0, 3'b010, 32'h004, 32'h0, 32'h11223344, 0, 4'b0000, 32'h0,
         1'b0, 1'b0, 32'h11223344, 2);
    // illegal load code
    xact(1'b0, 3'b110, 32'h002, 32'h0, 32'h0, 0, 4'b0000, 32'h0,
         1'b0, 1'b1, 32'h11223344, 1);
    // misaligned SH
    xact(1'b1, 3'b001, 32'h001, 32'h5A5A, 32'h0, 0, 4'b0000, 32'h0,
         1'b1, 1'b0, 32'h11223344, 1);

    // stray mem_ready while idle
    @(negedge clk);
    ready_kick = 1'b1;
    @(negedge clk);
    ready_kick = 1'b0;
    chk("stray_ready_busy", 32'(busy), 32'd0);
    chk("stray_ready_rdata", rdata, 32'h11223344);

    // reset in the second ACCESS cycle
    rdly = NEVER;
    drive_req(1'b0, 3'b010, 32'h010, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    xact(1'b0, 3'b101, 32'h002, 32'h0, 32'h80010000, 0, 4'b0000, 32'h0,
         1'b0, 1'b0, 32'h00008001, 2);

    repeat (3) @(negedge clk);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
